// File: rtl/word_serializer.sv
// Packs a byte stream into WORD_BYTES-wide words and shifts each word out MSB-first on ser_out.
// Define WORD_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module word_serializer #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_frame,
  output logic       ser_last,
  output logic       busy,
  output logic [7:0] words_sent
);

  localparam int unsigned W = 8 * WORD_BYTES;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int unsigned FW = W + 1;
`else
  localparam int unsigned FW = W;
`endif
  localparam int unsigned BCW = $clog2(FW);
  localparam int unsigned CW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e          state_q;
  logic [CW-1:0]   byte_cnt_q;
  logic [W-1:0]    hold_word_q;
  logic            hold_full_q;
  logic [FW-1:0]   shift_q;
  logic [BCW-1:0]  bit_cnt_q;
  logic [7:0]      gap_cnt_q;

  logic            accept;
  logic            frame_end;
  logic            start;
  logic [FW-1:0]   load_word;

  always_comb begin
    accept    = in_valid && !hold_full_q;
    frame_end = (state_q == StShift) && (bit_cnt_q == '0);
    // A held word may launch from IDLE, at the end of a gap, or straight after a frame when
    // no gap is configured.
    start     = hold_full_q && ((state_q == StIdle) ||
                                ((state_q == StGap) && (gap_cnt_q == '0)) ||
                                (frame_end && (GAP_CYCLES == 0)));
`ifdef WORD_SERIALIZER_PARITY_EN
    load_word = {hold_word_q, ^hold_word_q};
`else
    load_word = hold_word_q;
`endif
  end

  assign in_ready = !hold_full_q;
  assign busy     = (state_q != StIdle) || hold_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      hold_word_q <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_out     <= IDLE_LEVEL;
      ser_frame   <= 1'b0;
      ser_last    <= 1'b0;
      words_sent  <= '0;
    end else begin
      if (accept) begin
        hold_word_q <= (hold_word_q << 8) | W'(in_data);
        if (byte_cnt_q == CW'(WORD_BYTES - 1)) begin
          hold_full_q <= 1'b1;
          byte_cnt_q  <= '0;
        end else begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end

      if (frame_end) begin
        words_sent <= words_sent + 8'd1;
      end

      if (start) begin
        // shift_q always holds the bits still to be presented, next one at the MSB.
        hold_full_q <= 1'b0;
        state_q     <= StShift;
        shift_q     <= load_word << 1;
        ser_out     <= load_word[FW-1];
        ser_frame   <= 1'b1;
        ser_last    <= 1'b0;
        bit_cnt_q   <= BCW'(FW - 1);
      end else begin
        unique case (state_q)
          StShift: begin
            if (!frame_end) begin
              shift_q   <= shift_q << 1;
              ser_out   <= shift_q[FW-1];
              ser_last  <= (bit_cnt_q == BCW'(1));
              bit_cnt_q <= bit_cnt_q - 1'b1;
            end else begin
              ser_out   <= IDLE_LEVEL;
              ser_frame <= 1'b0;
              ser_last  <= 1'b0;
              if (GAP_CYCLES > 0) begin
                state_q   <= StGap;
                gap_cnt_q <= 8'(GAP_CYCLES - 1);
              end else begin
                state_q <= StIdle;
              end
            end
          end
          StGap: begin
            if (gap_cnt_q != '0) begin
              gap_cnt_q <= gap_cnt_q - 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: two instances (no gap, 3-cycle gap) checked every cycle against a
// frame-timeline model, plus directed literal expectations.
module tb_word_serializer;

`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FL = 33;
`else
  localparam int FL = 32;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       v     [2];
  logic       rdy   [2];
  logic       sout  [2];
  logic       frame [2];
  logic       last  [2];
  logic       bsy   [2];
  logic [7:0] ws    [2];

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  word_serializer #(.WORD_BYTES(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(v[0]), .in_ready(rdy[0]),
    .ser_out(sout[0]), .ser_frame(frame[0]), .ser_last(last[0]), .busy(bsy[0]),
    .words_sent(ws[0])
  );

  word_serializer #(.WORD_BYTES(4), .GAP_CYCLES(3), .IDLE_LEVEL(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(v[1]), .in_ready(rdy[1]),
    .ser_out(sout[1]), .ser_frame(frame[1]), .ser_last(last[1]), .busy(bsy[1]),
    .words_sent(ws[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic exp_bit(input logic [31:0] w, input int p);
    if (p < 32) return w[31-p];
    return ^w;
  endfunction

  // Model: frame position shown on the line (-1 = none), remaining gap cycles, holding buffer.
  int          m_pos  [2];
  int          m_gap  [2];
  int          m_nb   [2];
  int          m_sent [2];
  bit          m_full [2];
  logic [31:0] m_hold [2];
  logic [31:0] m_cur  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pos[i]  <= -1;
        m_gap[i]  <= 0;
        m_nb[i]   <= 0;
        m_sent[i] <= 0;
        m_full[i] <= 0;
        m_hold[i] <= '0;
      end else begin
        if (m_pos[i] == FL - 1) m_sent[i] <= (m_sent[i] + 1) % 256;
        if (m_full[i] && ((m_pos[i] < 0 && m_gap[i] == 0) || m_gap[i] == 1 ||
                          (m_pos[i] == FL - 1 && gap_of(i) == 0))) begin
          m_cur[i]  <= m_hold[i];
          m_pos[i]  <= 0;
          m_gap[i]  <= 0;
          m_full[i] <= 0;
        end else if (m_pos[i] >= 0 && m_pos[i] < FL - 1) begin
          m_pos[i] <= m_pos[i] + 1;
        end else if (m_pos[i] == FL - 1) begin
          m_pos[i] <= -1;
          m_gap[i] <= gap_of(i);
        end else if (m_gap[i] > 0) begin
          m_gap[i] <= m_gap[i] - 1;
        end
        if (v[i] && !m_full[i]) begin
          m_hold[i] <= {m_hold[i][23:0], din};
          if (m_nb[i] == 3) begin
            m_full[i] <= 1;
            m_nb[i]   <= 0;
          end else begin
            m_nb[i] <= m_nb[i] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk((i == 0) ? "model_gap0" : "model_gap3",
            {51'd0, rdy[i], sout[i], frame[i], last[i], bsy[i], ws[i]},
            {51'd0, !m_full[i], (m_pos[i] >= 0) ? exp_bit(m_cur[i], m_pos[i]) : 1'b0,
             m_pos[i] >= 0, m_pos[i] == FL - 1,
             (m_pos[i] >= 0) || (m_gap[i] > 0) || m_full[i], 8'(m_sent[i])});
      end
    end
  end

  // Run-length monitor for frame and idle stretches.
  int frame_run [2] = '{0, 0};
  int idle_run  [2] = '{0, 0};
  int last_frame_run [2] = '{0, 0};
  int last_idle_run  [2] = '{0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        if (frame[i]) begin
          frame_run[i] <= frame_run[i] + 1;
          idle_run[i]  <= 0;
          if (idle_run[i] != 0) last_idle_run[i] <= idle_run[i];
        end else begin
          idle_run[i]  <= idle_run[i] + 1;
          frame_run[i] <= 0;
          if (frame_run[i] != 0) last_frame_run[i] <= frame_run[i];
        end
      end
    end
  end

  task automatic send_byte(input int i, input logic [7:0] b);
    int n = 0;
    din  = b;
    v[i] = 1'b1;
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", rdy[i]);
    end
    @(negedge clk);
    v[i] = 1'b0;
  endtask

  task automatic send_word(input int i, input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(i, w[8*b +: 8]);
  endtask

  task automatic wait_ws(input int i, input logic [7:0] target);
    int n = 0;
    while (ws[i] != target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_total++;
      $display("FAIL wait_words_sent: got %0d required %0d", ws[i], target);
    end
  endtask

  task automatic collect(input int i, output logic [63:0] bits, output int nf, output int lp);
    bits = '0;
    nf   = 0;
    lp   = -1;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      bits = {bits[62:0], sout[i]};
      if (frame[i]) nf++;
      if (last[i]) lp = (lp == -1) ? k : -2;
    end
  endtask

  logic [63:0] bits;
  int          nf;
  int          lp;

  initial begin
    rst  = 1'b1;
    din  = '0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("reset_outputs0", {rdy[0], sout[0], frame[0], last[0], bsy[0], ws[0]}, {5'b10000, 8'd0});
    chk("reset_outputs1", {rdy[1], sout[1], frame[1], last[1], bsy[1], ws[1]}, {5'b10000, 8'd0});
    rst = 1'b0;

    // Single word, MSB first.
    send_word(0, 32'hDEADBEEF);
    collect(0, bits, nf, lp);
    chk("deadbeef_bits", (bits >> (FL - 32)) & 64'hFFFF_FFFF, 64'hDEAD_BEEF);
    chk("deadbeef_frame_len", 64'(nf), 64'(FL));
    chk("deadbeef_last_pos", 64'(lp), 64'(FL - 1));
    @(negedge clk);
    chk("deadbeef_after_frame", {frame[0], ws[0]}, {1'b0, 8'd1});

    // Back-to-back words with no gap.
    send_word(0, 32'h12345678);
    send_word(0, 32'hFFFF0000);
    chk("b2b_ready_low", rdy[0], 1'b0);
    chk("b2b_busy", bsy[0], 1'b1);
    wait_ws(0, 8'd3);
    repeat (2) @(negedge clk);
    chk("b2b_contiguous", 64'(last_frame_run[0]), 64'(2 * FL));
    chk("b2b_words_sent", ws[0], 8'd3);

    // Three-cycle gap between queued frames.
    send_word(1, 32'hCAFEF00D);
    send_word(1, 32'h0BADC0DE);
    wait_ws(1, 8'd2);
    repeat (2) @(negedge clk);
    chk("gap_idle_cycles", 64'(last_idle_run[1]), 64'd3);
    chk("gap_frame_len", 64'(last_frame_run[1]), 64'(FL));

    // Reset in the middle of a frame with a second word held.
    send_word(0, 32'h11223344);
    send_word(0, 32'h55667788);
    begin
      int n = 0;
      while (m_pos[0] != 10 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("pre_rst_held", rdy[0], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_outputs", {rdy[0], sout[0], frame[0], last[0], bsy[0], ws[0]},
        {5'b10000, 8'd0});
    nf = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame[0]) nf++;
    end
    chk("no_frame_after_rst", 64'(nf), 64'd0);
    send_word(0, 32'hA5C30F96);
    wait_ws(0, 8'd1);
    chk("post_rst_words_sent", ws[0], 8'd1);

    // Backpressure: third word offered while one shifts and one is held.
    send_word(0, 32'h01020304);
    send_word(0, 32'hF0E0D0C0);
    for (int k = 0; k < 8; k++) begin
      din  = 8'h70 + 8'(k);
      v[0] = k[0];
      @(negedge clk);
      chk("backpressure_ready", rdy[0], 1'b0);
    end
    v[0] = 1'b0;
    send_word(0, 32'h9ABCDEF0);
    wait_ws(0, 8'd4);
    chk("backpressure_words_sent", ws[0], 8'd4);

`ifdef WORD_SERIALIZER_PARITY_EN
    repeat (2) @(negedge clk);
    send_word(0, 32'h00000001);
    collect(0, bits, nf, lp);
    chk("par1_bit0", bits[1], 1'b1);
    chk("par1_parity", bits[0], 1'b1);
    chk("par1_len", 64'(nf), 64'd33);
    chk("par1_last_pos", 64'(lp), 64'd32);
    send_word(0, 32'h00000003);
    collect(0, bits, nf, lp);
    chk("par3_word", bits[32:1], 32'h00000003);
    chk("par3_parity", bits[0], 1'b0);
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Upstream feeder for the serial shift-register stage: packs bytes from a valid/ready stream into 32-bit words and shifts each word out MSB-first, one bit per clk, on a single serial line.
- One holding word is buffered, so the next word can be collected while the current one shifts and frames go out back-to-back.
- Provides frame/last strobes and a sent-word counter for the bench and the downstream stage.

Parameters:
- WORD_BYTES, 4, bytes per word; word width = 8*WORD_BYTES.
- GAP_CYCLES, 0, idle cycles forced between consecutive frames (0..255).
- IDLE_LEVEL, 0, ser_out level outside frames.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  reset: synchronous, active-high.
- in_data  input  8  byte to pack; first byte of a word is its MS byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a byte.
- ser_out  output  1  serial bit, registered.
- ser_frame  output  1  high for every cycle ser_out carries a frame bit.
- ser_last  output  1  high with the final bit of a frame.
- busy  output  1  high while the FSM is in SHIFT or GAP, or the holding word is full.
- words_sent  output  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset (rst=1 at an edge): in_ready=1, ser_out=IDLE_LEVEL, ser_frame=0, ser_last=0, busy=0, words_sent=0. The byte counter, holding word and shifter are cleared. A partial word or an in-flight frame is discarded with no truncated ser_last. rst has priority over every other event.
- Packing: a byte is accepted at an edge with in_valid && in_ready. Bytes fill from the MS byte down. On the WORD_BYTES-th accept, hold_full is set and the byte counter returns to 0.
- in_ready = !hold_full (combinational). in_valid is ignored while in_ready=0; in_data need not be held stable.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if hold_full at an edge, the holding word moves to the shifter, hold_full clears, and the FSM enters SHIFT. After that edge ser_out = word MSB and ser_frame=1.
  - SHIFT: each edge shifts left by one. A bit counter counts down from 8*WORD_BYTES-1. ser_last=1 while the counter is 0.
  - At the edge ending the last bit, words_sent increments. Then:
    - GAP_CYCLES>0: enter GAP.
    - GAP_CYCLES=0 and hold_full: reload the shifter directly, so the next frame's MSB follows with no idle cycle.
    - Otherwise: go to IDLE.
  - GAP: ser_out=IDLE_LEVEL, ser_frame=0 for exactly GAP_CYCLES cycles, then the same decision as IDLE.
- Latency: 4th byte accepted at edge N -> bit31 visible after edge N+1 -> bit0 visible after edge N+32 with ser_last=1. The frame is 32 cycles wide.
- Buffer handling: hold_full clears on the transfer edge, so in_ready is high again the next cycle. While the shifter is busy and hold_full=1, in_ready stays 0.
- Simultaneous events: an accept and a transfer never coincide, because transfer requires hold_full and accept requires !hold_full.
- Outside frames: ser_out=IDLE_LEVEL, ser_frame=0, ser_last=0.

Optional Feature:
- Macro: WORD_SERIALIZER_PARITY_EN.
- Defined: one extra bit follows bit0 of each frame. It is the even-parity bit (XOR of all word bits), with ser_frame=1 and ser_last=1 on the parity cycle; bit0 has ser_last=0. The frame is 33 cycles.
- Undefined: no parity bit; frame is exactly 8*WORD_BYTES cycles.

Test Plan:
- Reset, then bytes DE,AD,BE,EF on consecutive cycles -> from 2 cycles after last accept, ser_out over 32 cycles = 0xDEADBEEF MSB-first. ser_frame=1 for exactly those 32 cycles, ser_last only on the 32nd, words_sent=1.
- Two words 0x12345678 and 0xFFFF0000 streamed continuously, GAP_CYCLES=0:
  - in_ready drops while the second word is held.
  - 64 contiguous ser_frame cycles, no idle cycle between frames.
  - words_sent=2.
- GAP_CYCLES=3, two words queued -> exactly 3 cycles of ser_out=IDLE_LEVEL, ser_frame=0 between frames.
- rst asserted on bit 10 of a frame with a second word held -> the next cycle has all outputs at reset values and words_sent=0. Neither word is emitted after rst falls. A new 4-byte word then serializes normally.
- Third word offered while the first shifts and the second is held -> in_ready=0 and in_data ignored until the second word transfers. Toggling in_valid during backpressure causes no accept.
- With WORD_SERIALIZER_PARITY_EN, word 0x00000001 -> 33-cycle frame with bit0=1, parity bit=1, ser_last on cycle 33. Word 0x00000003 -> parity bit=0.
